fetch_unit: RTL and testbench

- Instruction fetch stage that drives the address side of the 8 KB BSRAM instruction memory (2048 x 32 words, 1-cycle synchronous read) and consumes its read data.
- Keeps the PC and issues one word read per cycle when there is space.
- Buffers returned words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing queued and in-flight words.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, one-cycle BSRAM read issue,
// 2-entry output queue toward decode, and redirect flush handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned AW       = 11,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_en,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          imem_ce,
  output logic          imem_oce,
  output logic [AW-1:0] imem_ad,
  input  logic [31:0]   imem_dout,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_instr
);

  // Occupancy limit: queued words plus the read in flight may never exceed it.
  localparam logic [2:0] CAP = 3'(DEPTH);

  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [1:0]  count;
  logic [31:0] q1_pc;
  logic [31:0] q1_instr;

  logic [31:0] tgt;
  logic [31:0] issue_pc;
  logic [2:0]  occ;
  logic        pop;
  logic        push;
  logic        issue;
  logic        unused_rpc;

  // Low address bits of a redirect target are ignored.
  assign unused_rpc = ^redirect_pc[1:0];

  // Issue decision and read address; a redirect flushes everything, so it
  // always has room for its own target.
  always_comb begin
    tgt      = {redirect_pc[31:2], 2'b00};
    issue_pc = redirect_valid ? tgt : pc;
    pop      = if_valid & if_ready;
    push     = inflight & ~redirect_valid;
    occ      = 3'(count) + 3'(inflight);
    issue    = fetch_en & ~reset & (redirect_valid | (occ < (CAP + 3'(pop))));
  end

  assign imem_ce  = issue;
  assign imem_oce = 1'b1;
  assign imem_ad  = issue_pc[AW+1:2];

  // PC, in-flight tracking and the two-entry queue with registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= 2'd0;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_instr    <= 32'h0;
      q1_pc       <= 32'h0;
      q1_instr    <= 32'h0;
    end else begin
      inflight    <= issue;
      inflight_pc <= issue_pc;

      if (issue) begin
        pc <= issue_pc + 32'd4;
      end else if (redirect_valid) begin
        pc <= tgt;
      end

      if (redirect_valid) begin
        count    <= 2'd0;
        if_valid <= 1'b0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (count == 2'd2) begin
              if_pc    <= q1_pc;
              if_instr <= q1_instr;
              q1_pc    <= inflight_pc;
              q1_instr <= imem_dout;
            end else begin
              if_pc    <= inflight_pc;
              if_instr <= imem_dout;
            end
          end
          2'b01: begin
            if (count == 2'd2) begin
              if_pc    <= q1_pc;
              if_instr <= q1_instr;
            end
            count    <= count - 2'd1;
            if_valid <= (count == 2'd2);
          end
          2'b10: begin
            if (count == 2'd0) begin
              if_pc    <= inflight_pc;
              if_instr <= imem_dout;
            end else begin
              q1_pc    <= inflight_pc;
              q1_instr <= imem_dout;
            end
            count    <= count + 2'd1;
            if_valid <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects,
// fetch_en gaps and 8 KB address wrap.
module tb_fetch_unit;

  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          if_ready;

  logic          imem_ce, imem_oce;
  logic [AW-1:0] imem_ad;
  logic [31:0]   imem_dout;
  logic          if_valid;
  logic [31:0]   if_pc, if_instr;

  logic          w_ce, w_oce;
  logic [AW-1:0] w_ad;
  logic [31:0]   w_dout;
  logic          w_valid;
  logic [31:0]   w_pc, w_instr;

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_log[$];
  logic [31:0] exp_log[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .AW(AW), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_ce(imem_ce), .imem_oce(imem_oce), .imem_ad(imem_ad),
    .imem_dout(imem_dout), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  fetch_unit #(.RESET_PC(32'h0000_1FFC), .AW(AW), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_ce(w_ce), .imem_oce(w_oce), .imem_ad(w_ad),
    .imem_dout(w_dout), .if_valid(w_valid), .if_ready(if_ready),
    .if_pc(w_pc), .if_instr(w_instr)
  );

  // BSRAM models preloaded with word[k] = 0x1000_0000 + k.
  always @(posedge clk) begin
    if (imem_ce) imem_dout <= 32'h1000_0000 + 32'(imem_ad);
    if (w_ce)    w_dout    <= 32'h1000_0000 + 32'(w_ad);
  end

  // Record every word decode accepts on the main instance.
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) acc_log.push_back(if_pc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Hold reset for two edges; returns at the start of the first released cycle.
  task automatic do_reset();
    reset          = 1'b1;
    fetch_en       = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    acc_log.delete();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(acc_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < acc_log.size()) chk($sformatf("%s_%0d", tag, i), acc_log[i], exp_log[i]);
    end
    exp_log.delete();
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    #1;
    settle();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_ce", 32'(imem_ce), 32'd0);
    chk("rst_oce", 32'(imem_oce), 32'd1);

    // Streaming start and backpressure at 0x10.
    do_reset();
    settle();
    chk("s1_c0_ce", 32'(imem_ce), 32'd1);
    chk("s1_c0_ad", 32'(imem_ad), 32'h0);
    chk("s1_c0_valid", 32'(if_valid), 32'd0);
    next(); settle();
    chk("s1_c1_ad", 32'(imem_ad), 32'h1);
    chk("s1_c1_valid", 32'(if_valid), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      next(); settle();
      chk("s1_valid", 32'(if_valid), 32'd1);
      chk("s1_pc", if_pc, 32'(4 * (k - 2)));
      chk("s1_instr", if_instr, 32'h1000_0000 + 32'(k - 2));
    end
    next(); if_ready = 1'b0; settle();
    chk("bp_c6_ce", 32'(imem_ce), 32'd0);
    chk("bp_c6_pc", if_pc, 32'h10);
    chk("bp_c6_instr", if_instr, 32'h1000_0004);
    for (int k = 7; k <= 10; k++) begin
      next(); settle();
      chk("bp_hold_valid", 32'(if_valid), 32'd1);
      chk("bp_hold_pc", if_pc, 32'h10);
      chk("bp_hold_instr", if_instr, 32'h1000_0004);
      chk("bp_hold_ce", 32'(imem_ce), 32'd0);
    end
    next(); if_ready = 1'b1; settle();
    chk("bp_c11_pc", if_pc, 32'h10);
    chk("bp_c11_ce", 32'(imem_ce), 32'd1);
    chk("bp_c11_ad", 32'(imem_ad), 32'h6);
    next(); settle();
    chk("bp_c12_pc", if_pc, 32'h14);
    chk("bp_c12_instr", if_instr, 32'h1000_0005);
    next(); settle();
    chk("bp_c13_pc", if_pc, 32'h18);
    chk("bp_c13_instr", if_instr, 32'h1000_0006);
    next();
    exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
    check_log("bp_log");

    // Redirect while the queue holds 0x8 and 0xC.
    do_reset();
    next(); next(); next();
    next(); if_ready = 1'b0; settle();
    chk("rd_c4_ce", 32'(imem_ce), 32'd0);
    next(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; settle();
    chk("rd_c5_pc", if_pc, 32'h8);
    chk("rd_c5_ad", 32'(imem_ad), 32'h10);
    chk("rd_c5_ce", 32'(imem_ce), 32'd1);
    next(); redirect_valid = 1'b0; if_ready = 1'b1; settle();
    chk("rd_c6_valid", 32'(if_valid), 32'd0);
    next(); settle();
    chk("rd_c7_valid", 32'(if_valid), 32'd1);
    chk("rd_c7_pc", if_pc, 32'h40);
    chk("rd_c7_instr", if_instr, 32'h1000_0010);
    next(); settle();
    chk("rd_c8_pc", if_pc, 32'h44);
    chk("rd_c8_instr", if_instr, 32'h1000_0011);
    next();
    exp_log = '{32'h0, 32'h4, 32'h40, 32'h44};
    check_log("rd_log");

    // Redirect coinciding with a pop and a response arrival.
    do_reset();
    next(); next(); next();
    next(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; settle();
    chk("rp_c4_pc", if_pc, 32'h8);
    chk("rp_c4_ce", 32'(imem_ce), 32'd1);
    chk("rp_c4_ad", 32'(imem_ad), 32'h40);
    next(); redirect_valid = 1'b0; settle();
    chk("rp_c5_valid", 32'(if_valid), 32'd0);
    next(); settle();
    chk("rp_c6_pc", if_pc, 32'h100);
    chk("rp_c6_instr", if_instr, 32'h1000_0040);
    next(); settle();
    chk("rp_c7_pc", if_pc, 32'h104);
    chk("rp_c7_instr", if_instr, 32'h1000_0041);
    next();
    exp_log = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    check_log("rp_log");

    // fetch_en low for three cycles with pc at 0x20.
    do_reset();
    repeat (8) next();
    fetch_en = 1'b0; settle();
    chk("fe_c8_ce", 32'(imem_ce), 32'd0);
    chk("fe_c8_pc", if_pc, 32'h18);
    next(); settle();
    chk("fe_c9_ce", 32'(imem_ce), 32'd0);
    chk("fe_c9_pc", if_pc, 32'h1C);
    chk("fe_c9_valid", 32'(if_valid), 32'd1);
    next(); settle();
    chk("fe_c10_ce", 32'(imem_ce), 32'd0);
    chk("fe_c10_valid", 32'(if_valid), 32'd0);
    next(); fetch_en = 1'b1; settle();
    chk("fe_c11_ce", 32'(imem_ce), 32'd1);
    chk("fe_c11_ad", 32'(imem_ad), 32'h8);
    next(); settle();
    chk("fe_c12_valid", 32'(if_valid), 32'd0);
    next(); settle();
    chk("fe_c13_pc", if_pc, 32'h20);
    chk("fe_c13_instr", if_instr, 32'h1000_0008);
    next(); settle();
    chk("fe_c14_pc", if_pc, 32'h24);
    next();
    for (int i = 0; i < 10; i++) exp_log.push_back(32'(4 * i));
    check_log("fe_log");

    // Address wrap at the 8 KB window, then a redirect with fetch_en low.
    do_reset();
    settle();
    chk("wr_c0_ce", 32'(w_ce), 32'd1);
    chk("wr_c0_ad", 32'(w_ad), 32'h7FF);
    next(); settle();
    chk("wr_c1_ad", 32'(w_ad), 32'h000);
    next(); settle();
    chk("wr_c2_pc", w_pc, 32'h0000_1FFC);
    chk("wr_c2_instr", w_instr, 32'h1000_07FF);
    next(); settle();
    chk("wr_c3_pc", w_pc, 32'h0000_2000);
    chk("wr_c3_instr", w_instr, 32'h1000_0000);
    next(); fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0202; settle();
    chk("rn_c4_ce", 32'(imem_ce), 32'd0);
    next(); fetch_en = 1'b1; redirect_valid = 1'b0; settle();
    chk("rn_c5_valid", 32'(if_valid), 32'd0);
    chk("rn_c5_ce", 32'(imem_ce), 32'd1);
    chk("rn_c5_ad", 32'(imem_ad), 32'h80);
    next(); settle();
    chk("rn_c6_valid", 32'(if_valid), 32'd0);
    next(); settle();
    chk("rn_c7_pc", if_pc, 32'h200);
    chk("rn_c7_instr", if_instr, 32'h1000_0080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
